kf_state_frame_tx: RTL and testbench

Downstream consumer of the Kalman filter state outputs. It snapshots the four 16-bit state words on filter update strobes, with optional decimation, and serializes each snapshot as an 11-byte framed packet over a byte-wide valid/ready stream. A UART or other link adapter sits after it. It runs on the filter clock and uses the same clk_en step strobe as the filter.

---
 rtl/kf_state_frame_tx_if.sv | 9 +
 rtl/kf_state_frame_tx.sv | 123 ++++++++++++
 tb/tb_kf_state_frame_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_state_frame_tx_if.sv
// Byte-wide valid/ready stream carrying framed Kalman state snapshots.
interface kf_state_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/kf_state_frame_tx.sv
// Snapshots the four Kalman state words on (decimated) clk_en strobes and
// streams each snapshot as an 11-byte frame: header, seq, 8 data bytes, checksum.
module kf_state_frame_tx #(
    parameter int unsigned DECIM    = 1,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic [15:0]                State0,
    input  logic [15:0]                State1,
    input  logic [15:0]                State2,
    input  logic [15:0]                State3,
    kf_state_frame_tx_if.master        tx,
    output logic                       busy,
    output logic [7:0]                 overrun_cnt
);
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned N_DATA   = 8;
    localparam logic [BYTE_W-1:0] DEC_LAST = BYTE_W'(DECIM - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DATA - 1);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [BYTE_W-1:0]   snap [N_DATA];
    logic [BYTE_W-1:0]   snap_nxt [N_DATA];
    logic [BYTE_W-1:0]   seq, seq_nxt;
    logic [BYTE_W-1:0]   csum, csum_nxt;
    logic [BYTE_W-1:0]   dec_cnt, dec_nxt;
    logic [BYTE_W-1:0]   ovr_nxt;
    logic [BYTE_W-1:0]   data_nxt;
    logic                valid_nxt;
    logic                fire, cap_evt, accept;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            snap        <= '{default: '0};
            seq         <= '0;
            csum        <= '0;
            dec_cnt     <= '0;
            overrun_cnt <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            snap        <= snap_nxt;
            seq         <= seq_nxt;
            csum        <= csum_nxt;
            dec_cnt     <= dec_nxt;
            overrun_cnt <= ovr_nxt;
            tx.tx_data  <= data_nxt;
            tx.tx_valid <= valid_nxt;
            busy        <= valid_nxt;
        end
    end

    // Next-state, capture/overrun decisions and next output byte
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        snap_nxt  = snap;
        seq_nxt   = seq;
        csum_nxt  = csum;
        dec_nxt   = dec_cnt;
        ovr_nxt   = overrun_cnt;
        data_nxt  = tx.tx_data;
        valid_nxt = 1'b0;

        fire    = tx.tx_valid && tx.tx_ready;
        cap_evt = clk_en && (dec_cnt == DEC_LAST);

        if (clk_en) begin
            dec_nxt = cap_evt ? '0 : dec_cnt + 8'd1;
        end

        case (state)
            HDR: if (fire) state_nxt = SEQ;
            SEQ: if (fire) begin
                state_nxt = DATA;
                idx_nxt   = '0;
                csum_nxt  = tx.tx_data;
            end
            DATA: if (fire) begin
                csum_nxt = csum + tx.tx_data;
                if (idx == IDX_LAST) state_nxt = CSUM;
                else                 idx_nxt   = idx + 3'd1;
            end
            CSUM: if (fire) begin
                state_nxt = IDLE;
                seq_nxt   = seq + 8'd1;
            end
            default: ;
        endcase

        // A capture lands only when the frame slot is free this cycle
        accept = cap_evt && ((state == IDLE) || ((state == CSUM) && fire));
        if (accept) begin
            state_nxt = HDR;
            snap_nxt  = '{State0[15:8], State0[7:0], State1[15:8], State1[7:0],
                          State2[15:8], State2[7:0], State3[15:8], State3[7:0]};
        end else if (cap_evt && (overrun_cnt != 8'hFF)) begin
            ovr_nxt = overrun_cnt + 8'd1;
        end

        // Stall keeps state_nxt/idx_nxt/csum_nxt unchanged, so the byte holds
        case (state_nxt)
            HDR:     data_nxt = HDR_BYTE;
            SEQ:     data_nxt = seq;
            DATA:    data_nxt = snap[idx_nxt];
            CSUM:    data_nxt = csum_nxt;
            default: data_nxt = '0;
        endcase
        valid_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_kf_state_frame_tx.sv
// Bench for kf_state_frame_tx: two instances (DECIM=1 and DECIM=4) checked every
// cycle against a frame-queue model, plus hand-computed frame literals.
module tb_kf_state_frame_tx;
    localparam int DEC0 = 1;
    localparam int DEC1 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  en;
    logic [15:0] s0, s1, s2, s3;
    logic        busy0, busy1;
    logic [7:0]  ovr0, ovr1;

    kf_state_frame_tx_if if0();
    kf_state_frame_tx_if if1();

    always #5 clk = ~clk;

    kf_state_frame_tx #(.DECIM(DEC0), .HDR_BYTE(8'hA5)) dut0 (
        .clk(clk), .reset(reset), .clk_en(en[0]),
        .State0(s0), .State1(s1), .State2(s2), .State3(s3),
        .tx(if0), .busy(busy0), .overrun_cnt(ovr0));

    kf_state_frame_tx #(.DECIM(DEC1), .HDR_BYTE(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .clk_en(en[1]),
        .State0(s0), .State1(s1), .State2(s2), .State3(s3),
        .tx(if1), .busy(busy1), .overrun_cnt(ovr1));

    int n_checks = 0;
    int n_errors = 0;

    // Model: the frame currently owed by each DUT, and the read position in it
    logic [7:0] mframe [2][11];
    int         mpos   [2];
    logic [7:0] mseq   [2];
    logic [7:0] movr   [2];
    int         mpulse [2];

    logic [7:0] log0 [$];
    logic [7:0] log1 [$];
    int         busy_cyc0;

    logic [7:0] exp1 [11] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08, 8'h24};

    function automatic logic dv(input int d);
        return (d == 0) ? if0.tx_valid : if1.tx_valid;
    endfunction
    function automatic logic dr(input int d);
        return (d == 0) ? if0.tx_ready : if1.tx_ready;
    endfunction
    function automatic logic [7:0] dd(input int d);
        return (d == 0) ? if0.tx_data : if1.tx_data;
    endfunction
    function automatic logic db(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic [7:0] dovr(input int d);
        return (d == 0) ? ovr0 : ovr1;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mpos[d]   = 11;
            mseq[d]   = 8'h00;
            movr[d]   = 8'h00;
            mpulse[d] = 0;
        end
    endtask

    // Advance one DUT's model across the coming rising edge
    task automatic model_step(input int d);
        logic        cap;
        logic [7:0]  sum;
        logic [63:0] w;
        int          dec;
        dec = (d == 0) ? DEC0 : DEC1;
        if (mpos[d] < 11 && dr(d)) begin
            mpos[d]++;
            if (mpos[d] == 11) mseq[d] = mseq[d] + 8'd1;
        end
        cap = 1'b0;
        if (en[d]) begin
            if (mpulse[d] == dec - 1) begin
                cap = 1'b1;
                mpulse[d] = 0;
            end else begin
                mpulse[d]++;
            end
        end
        if (cap) begin
            if (mpos[d] == 11) begin
                w = {s0, s1, s2, s3};
                mframe[d][0] = 8'hA5;
                mframe[d][1] = mseq[d];
                sum = mseq[d];
                for (int k = 0; k < 8; k++) begin
                    mframe[d][2+k] = w[63-8*k -: 8];
                    sum = sum + w[63-8*k -: 8];
                end
                mframe[d][10] = sum;
                mpos[d] = 0;
            end else if (movr[d] != 8'hFF) begin
                movr[d] = movr[d] + 8'd1;
            end
        end
    endtask

    // Per-cycle compare against the model, transfer logging, model update
    always @(negedge clk) begin
        if (reset) model_clear();
        for (int d = 0; d < 2; d++) begin
            chk("tx_valid", d, 32'(dv(d)), 32'(mpos[d] < 11));
            chk("busy", d, 32'(db(d)), 32'(mpos[d] < 11));
            chk("overrun_cnt", d, 32'(dovr(d)), 32'(movr[d]));
            if (mpos[d] < 11) chk("tx_data", d, 32'(dd(d)), 32'(mframe[d][mpos[d]]));
            if (!reset) begin
                if (dv(d) && dr(d)) begin
                    if (d == 0) log0.push_back(dd(0));
                    else        log1.push_back(dd(1));
                end
                if (d == 0 && db(0)) busy_cyc0++;
                model_step(d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d);
        en[d] = 1'b1;
        tick();
        en[d] = 1'b0;
    endtask

    task automatic set_states(input logic [15:0] a, b, c, e);
        s0 = a; s1 = b; s2 = c; s3 = e;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_log0(input int n, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && log0.size() < n; i++) tick();
        chk(name, 0, 32'(log0.size()), 32'(n));
    endtask

    task automatic chk_frame0(input string name, input int base, input logic [7:0] seqb,
                              input logic [7:0] csb);
        for (int i = 0; i < 11; i++) begin
            if (i == 1)       chk(name, 0, 32'(log0[base+i]), 32'(seqb));
            else if (i == 10) chk(name, 0, 32'(log0[base+i]), 32'(csb));
            else              chk(name, 0, 32'(log0[base+i]), 32'(exp1[i]));
        end
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        en = 2'b00;
        set_states(16'h0, 16'h0, 16'h0, 16'h0);
        if0.tx_ready = 1'b0;
        if1.tx_ready = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_tx_data", d, 32'(dd(d)), 32'h0);
            chk("rst_tx_valid", d, 32'(dv(d)), 32'h0);
            chk("rst_busy", d, 32'(db(d)), 32'h0);
            chk("rst_overrun", d, 32'(dovr(d)), 32'h0);
        end
        reset = 1'b0;
        tick();

        // Single frame, ready held high
        if0.tx_ready = 1'b1;
        log0.delete();
        busy_cyc0 = 0;
        set_states(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        pulse(0);
        chk("first_byte_hdr", 0, 32'(if0.tx_data), 32'hA5);
        wait_log0(11, 40, "single_len");
        repeat (3) tick();
        chk("single_busy_cycles", 0, 32'(busy_cyc0), 32'd11);
        chk_frame0("single_byte", 0, 8'h00, 8'h24);

        // Same stimulus under random backpressure; seq has moved to 01
        log0.delete();
        pulse(0);
        for (int i = 0; i < 400 && log0.size() < 11; i++) begin
            if0.tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if0.tx_ready = 1'b1;
        chk("bp_len", 0, 32'(log0.size()), 32'd11);
        chk_frame0("bp_byte", 0, 8'h01, 8'h25);

        // Overrun: stalled frame, three more captures dropped
        do_reset();
        if0.tx_ready = 1'b0;
        log0.delete();
        set_states(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        pulse(0);
        for (int i = 0; i < 3; i++) begin
            set_states(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            pulse(0);
            tick();
        end
        chk("overrun_3", 0, 32'(ovr0), 32'd3);
        if0.tx_ready = 1'b1;
        wait_log0(11, 40, "ovr_len");
        chk_frame0("ovr_first_snapshot", 0, 8'h00, 8'h24);
        log0.delete();
        pulse(0);
        wait_log0(11, 40, "ovr_next_len");
        chk("ovr_next_seq", 0, 32'(log0[1]), 32'h01);

        // Back-to-back: capture in the cycle of the CSUM transfer
        do_reset();
        if0.tx_ready = 1'b1;
        log0.delete();
        set_states(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        pulse(0);
        repeat (10) tick();
        set_states(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        pulse(0);
        chk("b2b_hdr_now", 0, 32'(if0.tx_data), 32'hA5);
        chk("b2b_valid_now", 0, 32'(if0.tx_valid), 32'h1);
        wait_log0(22, 60, "b2b_len");
        chk("b2b_csum1", 0, 32'(log0[10]), 32'h24);
        chk("b2b_hdr2", 0, 32'(log0[11]), 32'hA5);
        chk("b2b_seq2", 0, 32'(log0[12]), 32'h01);
        chk("b2b_d0", 0, 32'(log0[13]), 32'h11);
        chk("b2b_csum2", 0, 32'(log0[21]), 32'h55);
        chk("b2b_overrun", 0, 32'(ovr0), 32'h0);

        // Decimation by 4 and seq wrap
        do_reset();
        if1.tx_ready = 1'b1;
        log1.delete();
        for (int p = 0; p < 1024; p++) begin
            set_states(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            pulse(1);
            repeat (19) tick();
        end
        repeat (20) tick();
        chk("dec_bytes", 1, 32'(log1.size()), 32'd2816);
        chk("dec_seq_first", 1, 32'(log1[1]), 32'h00);
        chk("dec_seq_last", 1, 32'(log1[255*11+1]), 32'hFF);
        for (int p = 0; p < 4; p++) begin
            pulse(1);
            repeat (19) tick();
        end
        chk("dec_bytes_257", 1, 32'(log1.size()), 32'd2827);
        chk("dec_seq_wrap", 1, 32'(log1[256*11+1]), 32'h00);
        chk("dec_overrun", 1, 32'(ovr1), 32'h0);

        // Reset during DATA byte 3 aborts the frame at once
        do_reset();
        if0.tx_ready = 1'b1;
        log0.delete();
        set_states(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        pulse(0);
        repeat (5) tick();
        chk("mid_d3_byte", 0, 32'(if0.tx_data), 32'h04);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 0, 32'(if0.tx_valid), 32'h0);
        chk("mid_rst_busy", 0, 32'(busy0), 32'h0);
        tick();
        reset = 1'b0;
        log0.delete();
        tick();
        set_states(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        pulse(0);
        wait_log0(11, 40, "mid_next_len");
        chk("mid_next_hdr", 0, 32'(log0[0]), 32'hA5);
        chk("mid_next_seq", 0, 32'(log0[1]), 32'h00);
        chk("mid_next_csum", 0, 32'(log0[10]), 32'h54);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
